// File: rtl/rfifo_reader_pkg.sv
// Shared types and width helpers for the rfifo read-side drain engine.
// Both the interface and the engine import this so beat-index widths always agree.
package rfifo_reader_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Beats per FIFO word, never less than one even for nonsensical widths.
    function automatic int calc_ratio(input int fifo_w, input int out_w);
        int r;
        r = (out_w > 0) ? (fifo_w / out_w) : 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Beat index width, clamped to one bit so RATIO=1 still has a usable index.
    function automatic int calc_cw(input int fifo_w, input int out_w);
        int r;
        r = calc_ratio(fifo_w, out_w);
        return (r <= 1) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/rfifo_reader_if.sv
// FIFO read port and narrow beat stream of the rfifo drain engine, bundled with modports.
// Stream handshake: a beat transfers on a rising clk edge where out_valid & out_ready; while
// out_valid=1 and out_ready=0 the producer holds out_data/out_last/out_beat stable.
interface rfifo_reader_if
    import rfifo_reader_pkg::*;
#(
    parameter int FIFO_DWIDTH = 32,
    parameter int OUT_DWIDTH  = 8,
    parameter int CW          = calc_cw(FIFO_DWIDTH, OUT_DWIDTH)
);
    logic                   fifo_empty;
    logic [FIFO_DWIDTH-1:0] fifo_dout;
    logic                   fifo_re;

    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_DWIDTH-1:0]  out_data;
    logic                   out_last;
    logic [CW-1:0]          out_beat;

    modport fifo_master (
        output fifo_re,
        input  fifo_empty,
        input  fifo_dout
    );

    modport fifo_slave (
        input  fifo_re,
        output fifo_empty,
        output fifo_dout
    );

    modport out_master (
        output out_valid,
        output out_data,
        output out_last,
        output out_beat,
        input  out_ready
    );

    modport out_slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_beat,
        output out_ready
    );

endinterface

// File: rtl/rfifo_reader.sv
// Drains wide words from a fall-through FIFO and serialises each one LSB-first into beats.
// The next word is popped in the same cycle the last beat is accepted, so a full FIFO streams gap-free.
module rfifo_reader
    import rfifo_reader_pkg::*;
#(
    parameter  int FIFO_DWIDTH = 32,
    parameter  int OUT_DWIDTH  = 8,
    localparam int RATIO       = calc_ratio(FIFO_DWIDTH, OUT_DWIDTH),
    localparam int CW          = calc_cw(FIFO_DWIDTH, OUT_DWIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    rfifo_reader_if.fifo_master        fifo,
    rfifo_reader_if.out_master         strm,
    output logic                       busy,
    output state_e                     dbg_state_o
);

    if ((OUT_DWIDTH > FIFO_DWIDTH) || ((FIFO_DWIDTH % OUT_DWIDTH) != 0)) begin : g_bad_width
        $error("rfifo_reader: FIFO_DWIDTH must be a whole multiple of OUT_DWIDTH");
    end

    localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

    state_e                             state_q, state_d;
    logic [FIFO_DWIDTH-1:0]             word_q,  word_d;
    logic [CW-1:0]                      beat_q,  beat_d;
    logic                               re_d;
    logic                               hold;
    logic                               last_beat;
    logic [RATIO-1:0][OUT_DWIDTH-1:0]   beats;

    assign hold      = (state_q == ST_HOLD);
    assign last_beat = (beat_q == LAST_BEAT);
    assign beats     = word_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        beat_d  = beat_q;
        re_d    = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (!fifo.fifo_empty && !flush) begin
                    re_d    = 1'b1;
                    word_d  = fifo.fifo_dout;
                    beat_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // flush wins over a same-cycle handshake: the presented beat is not consumed.
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (strm.out_ready) begin
                    if (!last_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else if (!fifo.fifo_empty) begin
                        re_d   = 1'b1;
                        word_d = fifo.fifo_dout;
                        beat_d = '0;
                    end else begin
                        beat_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (rst) begin
            re_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            beat_q  <= beat_d;
        end
    end

    assign fifo.fifo_re   = re_d;
    assign strm.out_valid = hold;
    assign strm.out_data  = hold ? beats[beat_q] : '0;
    assign strm.out_last  = hold & last_beat;
    assign strm.out_beat  = hold ? beat_q : '0;
    assign busy           = hold;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rfifo_reader.sv
// Bench for rfifo_reader: a 32/8 and a 32/32 instance, each fed by a depth-16 fall-through FIFO
// model and checked every cycle against a beat-queue reference model.
module tb_rfifo_reader;
    import rfifo_reader_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          idx;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ready;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_data;
    bit          chk_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic        obs_valid [2];
    logic        obs_fe    [2];
    int          obs_re_n  [2];
    logic [1:0]  obs_beat0;
    logic [7:0]  obs_data0;
    logic        obs_last0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- two configurations ----------------
    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int          OW    = (k == 0) ? 8 : 32;
        localparam int          RATIO = 32 / OW;
        localparam logic [31:0] MASK  = 32'hFFFF_FFFF >> (32 - OW);

        rfifo_reader_if #(.FIFO_DWIDTH(32), .OUT_DWIDTH(OW)) bus ();

        logic   busy_l;
        state_e state_l;

        rfifo_reader #(.FIFO_DWIDTH(32), .OUT_DWIDTH(OW)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .fifo        (bus),
            .strm        (bus),
            .busy        (busy_l),
            .dbg_state_o (state_l)
        );

        // Fall-through FIFO model: a write becomes visible at the head one cycle later.
        logic [31:0] fifo_q[$];
        logic        fe_q   = 1'b1;
        logic [31:0] dout_q = '0;
        int          re_n   = 0;

        assign bus.fifo_empty = fe_q;
        assign bus.fifo_dout  = dout_q;
        assign bus.out_ready  = ready;

        always @(posedge clk) begin
            if (bus.fifo_re) begin
                re_n <= re_n + 1;
                check($sformatf("c%0d no_underflow", k), 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (wr_en && fifo_q.size() < 16) fifo_q.push_back(wr_data);
            fe_q   <= (fifo_q.size() == 0);
            dout_q <= (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
        end

        assign obs_valid[k] = bus.out_valid;
        assign obs_fe[k]    = fe_q;
        assign obs_re_n[k]  = re_n;

        if (k == 0) begin : g_obs
            assign obs_beat0 = bus.out_beat;
            assign obs_data0 = bus.out_data;
            assign obs_last0 = bus.out_last;
        end

        // Reference model: the beats still owed for the held word, oldest first.
        beat_t exp_q[$];

        always @(negedge clk) begin : p_chk
            bit          ev;
            bit          ere;
            logic [31:0] w;
            #2;
            if (chk_en) begin
                ev  = (exp_q.size() != 0);
                ere = !rst && (fifo_q.size() != 0) && !flush &&
                      (!ev || (ready && exp_q.size() == 1));
                check($sformatf("c%0d out_valid", k), 32'(bus.out_valid), 32'(ev));
                check($sformatf("c%0d busy", k), 32'(busy_l), 32'(ev));
                check($sformatf("c%0d fifo_re", k), 32'(bus.fifo_re), 32'(ere));
                if (ev) begin
                    check($sformatf("c%0d out_data", k), 32'(bus.out_data), exp_q[0].data);
                    check($sformatf("c%0d out_last", k), 32'(bus.out_last),
                          32'(exp_q[0].idx == RATIO - 1));
                    check($sformatf("c%0d out_beat", k), 32'(bus.out_beat), 32'(exp_q[0].idx));
                end
                if (rst || flush) begin
                    exp_q.delete();
                end else begin
                    if (ev && ready) void'(exp_q.pop_front());
                    if (ere) begin
                        w = fifo_q[0];
                        for (int i = 0; i < RATIO; i++) begin
                            exp_q.push_back('{data: (w >> (i * OW)) & MASK, idx: i});
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_words(input logic [31:0] w0, input logic [31:0] w1, input int n);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = w0;
        if (n > 1) begin
            @(negedge clk);
            wr_data = w1;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_beat(input int b);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (obs_valid[0] && obs_beat0 == 2'(b)) found = 1'b1;
        end
        check($sformatf("wait beat %0d", b), 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : p_main
        int re0;
        rst     = 1'b1;
        ready   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        chk_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset valid0", 32'(obs_valid[0]), 32'd0);
        check("reset valid1", 32'(obs_valid[1]), 32'd0);
        check("reset data0", 32'(obs_data0), 32'd0);
        check("reset beat0", 32'(obs_beat0), 32'd0);
        check("reset last0", 32'(obs_last0), 32'd0);
        rst = 1'b0;

        // single word, consumer always ready
        ready = 1'b1;
        push_words(32'hDDCC_BBAA, 32'h0, 1);
        wait_beat(3);
        check("t1 last data", 32'(obs_data0), 32'hDD);
        check("t1 last flag", 32'(obs_last0), 32'd1);
        repeat (4) @(negedge clk);

        // two words back-to-back, no bubble
        re0 = obs_re_n[0];
        push_words(32'h4433_2211, 32'h8877_6655, 2);
        repeat (12) @(negedge clk);
        check("t2 pops", 32'(obs_re_n[0] - re0), 32'd2);
        check("t2 fifo empty", 32'(obs_fe[0]), 32'd1);
        check("t2 valid drop", 32'(obs_valid[0]), 32'd0);

        // back-pressure on beat 1
        ready = 1'b0;
        push_words(32'hDDCC_BBAA, 32'h0, 1);
        wait_beat(0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3 stall beat", 32'(obs_beat0), 32'd1);
            check("t3 stall data", 32'(obs_data0), 32'hBB);
        end
        ready = 1'b1;
        repeat (6) @(negedge clk);

        // flush after beat 1 of word 0
        ready = 1'b0;
        push_words(32'h0D0C_0B0A, 32'h1D1C_1B1A, 2);
        wait_beat(0);
        ready = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t4 idle after flush", 32'(obs_valid[0]), 32'd0);
        @(negedge clk);
        check("t4 next beat", 32'(obs_beat0), 32'd0);
        check("t4 next data", 32'(obs_data0), 32'h1A);
        repeat (8) @(negedge clk);

        // reset mid-word
        ready = 1'b0;
        push_words(32'h2D2C_2B2A, 32'h3D3C_3B3A, 2);
        wait_beat(0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 valid after rst", 32'(obs_valid[0]), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("t5 next beat", 32'(obs_beat0), 32'd0);
        check("t5 next data", 32'(obs_data0), 32'h3A);
        repeat (8) @(negedge clk);

        // empty FIFO with flush toggling
        repeat (20) begin
            @(negedge clk);
            flush = 1'($urandom_range(0, 1));
            check("t6 idle c0", 32'(obs_valid[0]), 32'd0);
            check("t6 idle c1", 32'(obs_valid[1]), 32'd0);
        end
        flush = 1'b0;

        // randomized traffic
        repeat (400) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = $urandom;
            ready   = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        ready = 1'b1;
        repeat (80) @(negedge clk);
        check("drain fifo c0", 32'(obs_fe[0]), 32'd1);
        check("drain fifo c1", 32'(obs_fe[1]), 32'd1);
        check("drain valid c0", 32'(obs_valid[0]), 32'd0);
        check("drain valid c1", 32'(obs_valid[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
